mode1_max_accum: RTL and testbench
==================================

// Module: mode1_max_accum
// PURPOSE
//  Streaming running-max stage for softmax mode 1: consumes LANES fp16 values per beat and
//  reduces one vector of num_beats beats to a single fp16 maximum.
//  Holds the running max that mode 1 feeds back as its external compare input.
//  Hands the final max downstream to the mode 2 (x - max) stage with a valid/ready handshake.
// PARAMETERS
//  DATAWIDTH  16   element width, IEEE fp16
//  LANES      4    elements per input beat
//  MAX_BEATS  256  largest vector length in beats
//  LEN_W      $clog2(MAX_BEATS+1)  beat-count width (derived, do not override)
// PORTS
//  clk        in   1                clock, all state on rising edge
//  reset      in   1                synchronous, active-high
//  start      in   1                begin new vector; sampled in IDLE only
//  num_beats  in   LEN_W            vector length in beats, sampled with start
//  in_valid   in   1                in_data beat valid
//  in_ready   out  1                stage accepts beat (ACCUM state only)
//  in_data    in   LANES*DATAWIDTH  lane i = bits [i*16 +: 16]
//  out_valid  out  1                final max available
//  out_ready  in   1                downstream accepts final max
//  out_max    out  DATAWIDTH        final vector maximum
//  busy       out  1                high in ACCUM or DONE
//  out_idx    out  LEN_W+2          element index of max (only with MODE1_MAX_INDEX_EN)
// BEHAVIOUR
//  - Reset values: in_ready=0, out_valid=0, out_max=16'h0000, busy=0, out_idx=0, state=IDLE.
//  - FSM: IDLE -> ACCUM on start && num_beats!=0; start with num_beats==0 is ignored (stays IDLE).
//    ACCUM -> DONE on the cycle the last beat is accepted. DONE -> IDLE on out_valid && out_ready.
//  - On entering ACCUM: running max = 16'hFC00 (-inf), beat counter = num_beats.
//  - Beat accepted when in_valid && in_ready; in_ready is 1 throughout ACCUM (no backpressure).
//  - Per accepted beat: running <= max(lane0..lane3, running); counter decrements.
//  - Latency: out_valid rises the cycle after the last beat is accepted; out_max is registered.
//  - DONE: out_valid and out_max held stable until out_ready; in_ready=0.
//  - start while busy is ignored. A start in the same cycle as the out handshake is ignored;
//    the next start is honoured one cycle later in IDLE.
//  - Compare order: sign-magnitude total order; +0 and -0 equal; NaN inputs unsupported (result unspecified).
//  - Ties: the earlier element keeps the max (lower lane in a beat, earlier beat across beats).
//  - reset asserted mid-ACCUM or mid-DONE aborts the vector and drops out_valid next edge; no partial result.
// CONFIGURATION
//  - MODE1_MAX_INDEX_EN defined: out_idx port exists; index = beat*LANES + lane of the winning element.
//    It is registered alongside out_max and follows the same tie rule.
//  - Not defined: out_idx port and index registers absent; all other behaviour identical.
// STRUCTURE
//  - softmax_pkg: DATAWIDTH, LANES, FP16_NEG_INF=16'hFC00, FSM state encodings
//    (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2).
//  - One sub-module fp16_max2: combinational 2-input fp16 max with index passthrough,
//    implementing the tie and zero rules.
//    Instantiate as a 4-lane tree (3 instances) plus 1 against running; no DesignWare dependency.
// TESTING
//  - num_beats=1, lanes {3C00,4000,BC00,0000} -> out_max=4000 one cycle after beat; out_idx=1.
//  - num_beats=3, all-negative beats, max C000 in beat 2 lane 3 -> out_max=C000, out_idx=11.
//  - Lanes {0000,8000,8000,0000} -> out_max=0000, out_idx=0 (tie keeps earliest);
//    equal maxima 3C00 in beats 0 and 2 -> out_idx from beat 0.
//  - out_ready low 5 cycles in DONE -> out_valid/out_max stable;
//    start pulsed in DONE ignored; next start accepted after handshake.
//  - reset pulsed after 2 of 4 beats -> out_valid stays 0; new vector then yields the correct max of its own beats only.
//  - start with num_beats=0 -> no state change; busy=0, in_ready=0.

Source files
------------

// File: rtl/softmax_pkg.sv
// Purpose : shared constants and FSM encoding for the softmax mode 1 running-max stage.
// Contents: element width, lane count, vector length limits, fp16 -inf constant,
//           and the three-state encoding used by mode1_max_accum.
package softmax_pkg;

    localparam int DATAWIDTH = 16;
    localparam int LANES     = 4;
    localparam int MAX_BEATS = 256;
    localparam int LEN_W     = $clog2(MAX_BEATS + 1);
    // Element index = beat * LANES + lane, so two extra bits hold the lane.
    localparam int IDX_W     = LEN_W + 2;

    localparam logic [DATAWIDTH-1:0] FP16_NEG_INF = 16'hFC00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fp16_max2.sv
// Purpose : combinational two-input fp16 maximum with a payload passthrough.
//           Operand A is the earlier element: on a tie A is returned, so callers
//           get "earliest element wins" by wiring the earlier value to A.
//           +0 and -0 compare equal; NaN is not supported.
// Ports   : i_a, i_b  {payload, fp16} operands, payload is IDX_W bits (may be 0)
//           o_max     the winning operand including its payload
module fp16_max2 #(
    parameter int IDX_W = 0
) (
    input  logic [16+IDX_W-1:0] i_a,
    input  logic [16+IDX_W-1:0] i_b,
    output logic [16+IDX_W-1:0] o_max
);

    // Maps sign-magnitude fp16 to an unsigned key with the same order.
    // Negative zero is treated as positive so both zeros get the same key.
    function automatic logic [15:0] fp16_key(input logic [15:0] v);
        logic is_neg;
        is_neg = v[15] && (v[14:0] != 15'd0);
        return is_neg ? {1'b0, ~v[14:0]} : {1'b1, v[14:0]};
    endfunction

    logic w_b_wins;

    // Strictly greater only, so equal values keep operand A.
    assign w_b_wins = fp16_key(i_b[15:0]) > fp16_key(i_a[15:0]);
    assign o_max    = w_b_wins ? i_b : i_a;

endmodule

// File: rtl/mode1_max_accum.sv
// Purpose : streaming running-max stage for softmax mode 1. Accepts LANES fp16
//           values per beat, reduces num_beats beats to one fp16 maximum and
//           hands it downstream with a valid/ready handshake.
// Option  : define MODE1_MAX_INDEX_EN to add out_idx, the element index
//           (beat*LANES + lane) of the winning element.
// Ports   : clk, reset (sync, active-high)
//           start, num_beats       begin a vector (honoured in IDLE only)
//           in_valid, in_ready, in_data   beat input, lane i = in_data[i*16 +: 16]
//           out_valid, out_ready, out_max final maximum handshake
//           busy                   high in ACCUM or DONE
//           out_idx                index of the max (MODE1_MAX_INDEX_EN only)
module mode1_max_accum
    import softmax_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [LEN_W-1:0]           num_beats,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*DATAWIDTH-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATAWIDTH-1:0]       out_max,
    output logic                       busy
`ifdef MODE1_MAX_INDEX_EN
    ,
    output logic [IDX_W-1:0]           out_idx
`endif
);

`ifdef MODE1_MAX_INDEX_EN
    localparam int PW = IDX_W;
`else
    localparam int PW = 0;
`endif

    state_t               r_state;
    state_t               w_next;
    logic [LEN_W-1:0]     r_cnt;
    logic [DATAWIDTH-1:0] r_max;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_load;

    logic [DATAWIDTH+PW-1:0] w_p0, w_p1, w_p2, w_p3;
    logic [DATAWIDTH+PW-1:0] w_m01, w_m23, w_mbeat, w_run, w_fin;

`ifdef MODE1_MAX_INDEX_EN
    logic [LEN_W-1:0] r_beat;
    logic [IDX_W-1:0] r_idx;

    assign w_p0  = {r_beat, 2'd0, in_data[0*DATAWIDTH +: DATAWIDTH]};
    assign w_p1  = {r_beat, 2'd1, in_data[1*DATAWIDTH +: DATAWIDTH]};
    assign w_p2  = {r_beat, 2'd2, in_data[2*DATAWIDTH +: DATAWIDTH]};
    assign w_p3  = {r_beat, 2'd3, in_data[3*DATAWIDTH +: DATAWIDTH]};
    assign w_run = {r_idx, r_max};
    assign out_idx = r_idx;
`else
    assign w_p0  = in_data[0*DATAWIDTH +: DATAWIDTH];
    assign w_p1  = in_data[1*DATAWIDTH +: DATAWIDTH];
    assign w_p2  = in_data[2*DATAWIDTH +: DATAWIDTH];
    assign w_p3  = in_data[3*DATAWIDTH +: DATAWIDTH];
    assign w_run = r_max;
`endif

    // Earlier element always sits on the A side so ties keep the earliest one;
    // the running max is A in the final stage because it comes from older beats.
    fp16_max2 #(.IDX_W(PW)) u_max_01  (.i_a(w_p0),    .i_b(w_p1),    .o_max(w_m01));
    fp16_max2 #(.IDX_W(PW)) u_max_23  (.i_a(w_p2),    .i_b(w_p3),    .o_max(w_m23));
    fp16_max2 #(.IDX_W(PW)) u_max_bt  (.i_a(w_m01),   .i_b(w_m23),   .o_max(w_mbeat));
    fp16_max2 #(.IDX_W(PW)) u_max_run (.i_a(w_run),   .i_b(w_mbeat), .o_max(w_fin));

    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign out_max   = r_max;

    assign w_accept = in_valid && in_ready;
    assign w_last   = w_accept && (r_cnt == {{(LEN_W-1){1'b0}}, 1'b1});
    assign w_load   = (r_state == ST_IDLE) && start && (num_beats != {LEN_W{1'b0}});

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_next = ST_ACCUM;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_DONE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register, beat counter and running max.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= {LEN_W{1'b0}};
            r_max   <= 16'h0000;
`ifdef MODE1_MAX_INDEX_EN
            r_beat  <= {LEN_W{1'b0}};
            r_idx   <= {IDX_W{1'b0}};
`endif
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_cnt <= num_beats;
                r_max <= FP16_NEG_INF;
`ifdef MODE1_MAX_INDEX_EN
                r_beat <= {LEN_W{1'b0}};
                r_idx  <= {IDX_W{1'b0}};
`endif
            end else if (w_accept) begin
                r_cnt <= r_cnt - {{(LEN_W-1){1'b0}}, 1'b1};
                r_max <= w_fin[DATAWIDTH-1:0];
`ifdef MODE1_MAX_INDEX_EN
                r_beat <= r_beat + {{(LEN_W-1){1'b0}}, 1'b1};
                r_idx  <= w_fin[DATAWIDTH +: IDX_W];
`endif
            end
        end
    end

endmodule

// File: tb/tb_mode1_max_accum.sv
module tb_mode1_max_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  num_beats;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_max;
    logic        busy;
`ifdef MODE1_MAX_INDEX_EN
    logic [10:0] out_idx;
`endif

    int total = 0;
    int bad   = 0;

    mode1_max_accum dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_beats (num_beats),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .busy      (busy)
`ifdef MODE1_MAX_INDEX_EN
        ,
        .out_idx   (out_idx)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; num_beats = 9'd0;
        in_valid = 1'b0; in_data = 64'd0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic send_start(input logic [8:0] nb);
        start = 1'b1; num_beats = nb;
        tick();
        start = 1'b0; num_beats = 9'd0;
    endtask

    // d = {lane3, lane2, lane1, lane0}
    task automatic send_beat(input logic [63:0] d);
        in_valid = 1'b1; in_data = d;
        tick();
        in_valid = 1'b0; in_data = 64'd0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_max !== 16'h0000) begin bad++; $display("FAIL reset_out_max got=%h want=0000", out_max); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
`ifdef MODE1_MAX_INDEX_EN
        total++; if (out_idx !== 11'd0) begin bad++; $display("FAIL reset_out_idx got=%0d want=0", out_idx); end
`endif
    endtask

    task automatic test_single();
        send_start(9'd1);
        total++; if (in_ready !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL single_accum got ready=%b busy=%b want 1 1", in_ready, busy); end
        send_beat({16'h0000, 16'hBC00, 16'h4000, 16'h3C00});
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", out_valid); end
        total++; if (out_max !== 16'h4000) begin bad++; $display("FAIL single_max got=%h want=4000", out_max); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL single_done_ready got=%b want=0", in_ready); end
`ifdef MODE1_MAX_INDEX_EN
        total++; if (out_idx !== 11'd1) begin bad++; $display("FAIL single_idx got=%0d want=1", out_idx); end
`endif
        handshake();
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_release got valid=%b busy=%b want 0 0", out_valid, busy); end
    endtask

    task automatic test_negative();
        send_start(9'd3);
        send_beat({16'hC200, 16'hCC00, 16'hC800, 16'hC400});
        // A bubble must not count as a beat.
        tick();
        total++; if (out_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL neg_bubble got valid=%b busy=%b want 0 1", out_valid, busy); end
        send_beat({16'hC100, 16'hC300, 16'hC500, 16'hC600});
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL neg_early_valid got=%b want=0", out_valid); end
        send_beat({16'hC000, 16'hC080, 16'hC900, 16'hC700});
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL neg_valid got=%b want=1", out_valid); end
        total++; if (out_max !== 16'hC000) begin bad++; $display("FAIL neg_max got=%h want=C000", out_max); end
`ifdef MODE1_MAX_INDEX_EN
        total++; if (out_idx !== 11'd11) begin bad++; $display("FAIL neg_idx got=%0d want=11", out_idx); end
`endif
        handshake();
    endtask

    task automatic test_ties();
        send_start(9'd1);
        send_beat({16'h0000, 16'h8000, 16'h8000, 16'h0000});
        total++; if (out_max !== 16'h0000) begin bad++; $display("FAIL tie_zero_max got=%h want=0000", out_max); end
`ifdef MODE1_MAX_INDEX_EN
        total++; if (out_idx !== 11'd0) begin bad++; $display("FAIL tie_zero_idx got=%0d want=0", out_idx); end
`endif
        handshake();
        // -0 first: the earliest zero keeps its own bit pattern.
        send_start(9'd1);
        send_beat({16'h8000, 16'h0000, 16'h0000, 16'h8000});
        total++; if (out_max !== 16'h8000) begin bad++; $display("FAIL tie_negzero_max got=%h want=8000", out_max); end
        handshake();
        send_start(9'd3);
        send_beat({16'h0000, 16'h0000, 16'h3C00, 16'h0000});
        send_beat({16'h3000, 16'h3400, 16'h3800, 16'h3800});
        send_beat({16'h3C00, 16'h0000, 16'h0000, 16'h3C00});
        total++; if (out_max !== 16'h3C00) begin bad++; $display("FAIL tie_beat_max got=%h want=3C00", out_max); end
`ifdef MODE1_MAX_INDEX_EN
        total++; if (out_idx !== 11'd1) begin bad++; $display("FAIL tie_beat_idx got=%0d want=1", out_idx); end
`endif
        handshake();
    endtask

    task automatic test_hold();
        send_start(9'd2);
        send_beat({16'h3C00, 16'h4000, 16'h3800, 16'h4200});
        send_beat({16'h4000, 16'h4400, 16'hC400, 16'h0000});
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                start = 1'b1; num_beats = 9'd1;
            end else begin
                start = 1'b0; num_beats = 9'd0;
            end
            tick();
            total++; if (out_valid !== 1'b1 || out_max !== 16'h4400) begin bad++; $display("FAIL hold_stable cyc=%0d got valid=%b max=%h want 1 4400", i, out_valid, out_max); end
        end
`ifdef MODE1_MAX_INDEX_EN
        total++; if (out_idx !== 11'd6) begin bad++; $display("FAIL hold_idx got=%0d want=6", out_idx); end
`endif
        // Start coincident with the handshake is ignored.
        out_ready = 1'b1; start = 1'b1; num_beats = 9'd1;
        tick();
        out_ready = 1'b0; start = 1'b0; num_beats = 9'd0;
        total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL hold_start_at_hs got busy=%b valid=%b want 0 0", busy, out_valid); end
        send_start(9'd1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL hold_restart got busy=%b want=1", busy); end
        send_beat({16'h4800, 16'h3C00, 16'h3C00, 16'h3C00});
        total++; if (out_valid !== 1'b1 || out_max !== 16'h4800) begin bad++; $display("FAIL hold_second got valid=%b max=%h want 1 4800", out_valid, out_max); end
`ifdef MODE1_MAX_INDEX_EN
        total++; if (out_idx !== 11'd3) begin bad++; $display("FAIL hold_second_idx got=%0d want=3", out_idx); end
`endif
        handshake();
    endtask

    task automatic test_reset_abort();
        send_start(9'd4);
        send_beat({16'h7000, 16'h7000, 16'h7000, 16'h7000});
        send_beat({16'h7400, 16'h7000, 16'h7000, 16'h7000});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_max !== 16'h0000) begin bad++; $display("FAIL abort_state got valid=%b busy=%b max=%h want 0 0 0000", out_valid, busy, out_max); end
        // Beats left over from the aborted vector must be ignored in IDLE.
        send_beat({16'h7800, 16'h7800, 16'h7800, 16'h7800});
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_idle_beat got valid=%b busy=%b want 0 0", out_valid, busy); end
        send_start(9'd2);
        send_beat({16'h3000, 16'h2000, 16'hB400, 16'h3000});
        send_beat({16'h3000, 16'h0000, 16'h3000, 16'h3400});
        total++; if (out_valid !== 1'b1 || out_max !== 16'h3400) begin bad++; $display("FAIL abort_new_max got valid=%b max=%h want 1 3400", out_valid, out_max); end
`ifdef MODE1_MAX_INDEX_EN
        total++; if (out_idx !== 11'd4) begin bad++; $display("FAIL abort_new_idx got=%0d want=4", out_idx); end
`endif
        handshake();
    endtask

    task automatic test_zero_len();
        send_start(9'd0);
        total++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL zero_len got busy=%b ready=%b valid=%b want 0 0 0", busy, in_ready, out_valid); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_len_later got busy=%b want=0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_negative();
        test_ties();
        test_hold();
        test_reset_abort();
        test_zero_len();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout got=stalled want=finished");
        $fatal(1, "timeout");
    end

endmodule
